// File: rtl/f1_lights_out_timer.sv
// rtl/f1_lights_out_timer.sv - lights-out delay generator and driver reaction timer
// Waits MIN_DELAY_MS + lfsr ms after all lights are lit, then times the driver's button press.
module f1_lights_out_timer #(
  parameter int MIN_DELAY_MS = 500,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_ms,
  input  logic             cmd_seq,
  input  logic             cmd_delay,
  input  logic             react,
  output logic             time_out,
  output logic             lights_off,
  output logic [CNT_W-1:0] reaction_ms,
  output logic             result_valid,
  output logic             jump_start
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TIMING, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DELAY_MS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state;
  logic [6:0]       lfsr;
  logic             seq_prev;
  logic             dly_prev;
  logic [CNT_W-1:0] dly_cnt;
  logic             seq_rise;
  logic             dly_rise;

  assign seq_rise = cmd_seq & ~seq_prev;
  assign dly_rise = cmd_delay & ~dly_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lfsr         <= 7'h01;
      seq_prev     <= 1'b0;
      dly_prev     <= 1'b0;
      dly_cnt      <= '0;
      time_out     <= 1'b0;
      lights_off   <= 1'b0;
      reaction_ms  <= '0;
      result_valid <= 1'b0;
      jump_start   <= 1'b0;
    end else begin
      // x^7 + x^6 + 1, maximal length, so a nonzero seed never reaches 0
      lfsr         <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      seq_prev     <= cmd_seq;
      dly_prev     <= cmd_delay;
      time_out     <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dly_rise) begin
            dly_cnt <= MIN_D + CNT_W'(lfsr);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (seq_rise) begin
            lights_off <= 1'b0;
            jump_start <= 1'b0;
            state      <= S_IDLE;
          end else if (react) begin
            jump_start   <= 1'b1;
            reaction_ms  <= '0;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else if (tick_ms) begin
            if (dly_cnt == ONE) begin
              time_out    <= 1'b1;
              lights_off  <= 1'b1;
              reaction_ms <= '0;
              state       <= S_TIMING;
            end else begin
              dly_cnt <= dly_cnt - ONE;
            end
          end
        end
        S_TIMING: begin
          // react outranks a coincident tick so that tick is never counted
          if (seq_rise) begin
            lights_off <= 1'b0;
            jump_start <= 1'b0;
            state      <= S_IDLE;
          end else if (react) begin
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else if (tick_ms && (reaction_ms != '1)) begin
            reaction_ms <= reaction_ms + ONE;
          end
        end
        S_DONE: begin
          if (seq_rise) begin
            lights_off <= 1'b0;
            jump_start <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_lights_out_timer.sv
// tb/tb_f1_lights_out_timer.sv - scoreboard bench for f1_lights_out_timer
module tb_f1_lights_out_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_ms = 1'b0;
  logic        cmd_seq = 1'b0;
  logic        cmd_delay = 1'b0;
  logic        react = 1'b0;
  logic        sat_en = 1'b0;
  logic        time_out, lights_off, result_valid, jump_start;
  logic [15:0] reaction_ms;
  logic        s_time_out, s_lights_off, s_result_valid, s_jump_start;
  logic [3:0]  s_reaction_ms;
  logic        s_cmd_delay, s_react;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_total = 0;
  int last_tick_cyc = -1;
  logic [6:0] lfsr_m;

  int   to_q[$];
  int   exp_ms[$];
  bit   exp_js[$];
  bit   exp_lo[$];
  int   sat_q[$];

  assign s_cmd_delay = cmd_delay & sat_en;
  assign s_react     = react & sat_en;

  f1_lights_out_timer #(.MIN_DELAY_MS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
    .react(react), .time_out(time_out), .lights_off(lights_off), .reaction_ms(reaction_ms),
    .result_valid(result_valid), .jump_start(jump_start)
  );

  f1_lights_out_timer #(.MIN_DELAY_MS(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .cmd_seq(cmd_seq), .cmd_delay(s_cmd_delay),
    .react(s_react), .time_out(s_time_out), .lights_off(s_lights_off), .reaction_ms(s_reaction_ms),
    .result_valid(s_result_valid), .jump_start(s_jump_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 7'h01;
    else     lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tick_ms) begin
      tick_total    <= tick_total + 1;
      last_tick_cyc <= cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a pulse
  always @(negedge clk) begin
    if (time_out) begin
      if (to_q.size() == 0) check("time_out_unexpected", 1, 0);
      else begin
        int e;
        e = to_q.pop_front();
        check("time_out_tick_count", tick_total, e);
        check("time_out_latency", last_tick_cyc, cyc);
      end
    end
    if (result_valid) begin
      if (exp_ms.size() == 0) check("result_unexpected", 1, 0);
      else begin
        check("reaction_ms", reaction_ms, exp_ms.pop_front());
        check("jump_start_at_result", jump_start, exp_js.pop_front());
        check("lights_off_at_result", lights_off, exp_lo.pop_front());
      end
    end
    if (s_result_valid) begin
      if (sat_q.size() == 0) check("sat_result_unexpected", 1, 0);
      else check("sat_reaction_ms", s_reaction_ms, sat_q.pop_front());
    end
    if (sat_en) check("sat_time_out_match", s_time_out, time_out);
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    clk_n(3);
    tick_ms = 1'b1;
    clk_n(1);
    tick_ms = 1'b0;
  endtask

  task automatic react_pulse(input int ms, input bit js, input bit lo, input bit with_tick);
    clk_n(3);
    react   = 1'b1;
    tick_ms = with_tick;
    exp_ms.push_back(ms);
    exp_js.push_back(js);
    exp_lo.push_back(lo);
    if (sat_en) sat_q.push_back(ms > 15 ? 15 : ms);
    clk_n(1);
    react   = 1'b0;
    tick_ms = 1'b0;
  endtask

  task automatic start_seq(input bit expect_to, input bit hold, input int max_l, output int l);
    int guard;
    guard = 0;
    cmd_seq = 1'b1;
    clk_n(1);
    while (int'(lfsr_m) > max_l && guard < 300) begin
      clk_n(1);
      guard++;
    end
    cmd_delay = 1'b1;
    l = int'(lfsr_m);
    if (expect_to) to_q.push_back(tick_total + 4 + l);
    clk_n(1);
    cmd_seq = 1'b0;
    if (!hold) cmd_delay = 1'b0;
  endtask

  initial begin
    int l;
    // 1: reset values
    clk_n(3);
    check("rst_time_out", time_out, 0);
    check("rst_lights_off", lights_off, 0);
    check("rst_reaction_ms", reaction_ms, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_jump_start", jump_start, 0);
    check("rst_lfsr", dut.lfsr, 7'h01);
    rst = 1'b0;
    clk_n(2);

    // 2: normal run, react 10 ticks after lights-out
    start_seq(1, 0, 127, l);
    repeat (4 + l) tick();
    clk_n(1);
    check("lights_off_after_time_out", lights_off, 1);
    repeat (10) tick();
    react_pulse(10, 0, 1, 0);

    // 3: jump start two ticks after the delay starts
    start_seq(0, 0, 127, l);
    repeat (2) tick();
    react_pulse(0, 1, 0, 0);
    clk_n(4);
    check("jump_start_sticky", jump_start, 1);
    check("jump_lights_off", lights_off, 0);

    // 4: tick and react in the same cycle at count 5
    start_seq(1, 0, 127, l);
    check("seq_rise_clears_jump", jump_start, 0);
    repeat (4 + l) tick();
    repeat (5) tick();
    react_pulse(5, 0, 1, 1);
    clk_n(2);
    check("reaction_ms_held", reaction_ms, 5);

    // 5: saturation on the 4-bit instance
    sat_en = 1'b1;
    start_seq(1, 0, 11, l);
    repeat (4 + l) tick();
    repeat (20) tick();
    check("sat_hold_f", s_reaction_ms, 4'hF);
    check("sat_lights_off", s_lights_off, 1);
    react_pulse(20, 0, 1, 0);
    clk_n(2);
    check("sat_jump_start", s_jump_start, 0);
    sat_en = 1'b0;

    // 6a: abort during WAIT
    start_seq(0, 0, 127, l);
    repeat (2) tick();
    cmd_seq = 1'b1;
    clk_n(1);
    cmd_seq = 1'b0;
    repeat (4 + l + 2) tick();
    check("abort_lights_off", lights_off, 0);
    check("abort_jump_start", jump_start, 0);

    // 6b: cmd_delay held high for 100 clks starts the delay once
    start_seq(1, 1, 127, l);
    repeat (25) tick();
    cmd_delay = 1'b0;
    for (int i = 25; i < 4 + l; i++) tick();
    repeat (3) tick();
    check("timing_lights_off", lights_off, 1);

    // 6c: reset in the middle of TIMING
    rst = 1'b1;
    #1;
    check("midrst_lights_off", lights_off, 0);
    check("midrst_reaction_ms", reaction_ms, 0);
    check("midrst_jump_start", jump_start, 0);
    check("midrst_time_out", time_out, 0);
    check("midrst_result_valid", result_valid, 0);
    clk_n(2);
    check("midrst_lfsr", dut.lfsr, 7'h01);
    rst = 1'b0;
    clk_n(4);

    check("to_q_drained", to_q.size(), 0);
    check("exp_q_drained", exp_ms.size(), 0);
    check("sat_q_drained", sat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
